// File: rtl/data_path.sv
// Single-bus datapath: register file, special registers, bus multiplexer and ALU.
// Transfers are steered one step per clock by one-hot strobes from the control unit.
module data_path (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] Mdatain,
    input  logic [15:0] ALUControl,
    input  logic [31:0] Rin,
    input  logic [31:0] Rout,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        RZout,
    input  logic        RYin,
    input  logic        RBin,
    input  logic        PCjump,
    input  logic        MDRread,
    output logic [31:0] BusMuxOut,
    output logic [31:0] IR,
    output logic [31:0] MAR
);

    logic [31:0] r_gpr [16];
    logic [31:0] r_hi, r_lo, r_zhi, r_zlo, r_pc, r_mdr, r_ir, r_mar, r_y, r_rb;

    logic [31:0] w_src [32];
    logic [31:0] w_bus;
    logic [31:0] w_c;
    logic [4:0]  w_sh;
    logic [5:0]  w_sh_inv;
    logic [31:0] w_sra;
    logic [63:0] w_prod;
    logic [31:0] w_div_a, w_div_b, w_quo_m, w_rem_m, w_quo, w_rem;
    logic [63:0] w_alu;

    assign w_c = {{13{r_ir[18]}}, r_ir[18:0]};

    always_comb begin
        for (int i = 0; i < 16; i++) w_src[i] = r_gpr[i];
        if (RZout) w_src[0] = '0;
        w_src[16] = r_hi;
        w_src[17] = r_lo;
        w_src[18] = r_zhi;
        w_src[19] = r_zlo;
        w_src[20] = r_pc;
        w_src[21] = r_mdr;
        w_src[22] = r_rb;
        w_src[23] = w_c;
        for (int i = 24; i < 32; i++) w_src[i] = '0;
    end

    // Scan from the top so the lowest set select is the last (winning) assignment.
    always_comb begin
        w_bus = '0;
        for (int i = 31; i >= 0; i--) begin
            if (Rout[i]) w_bus = w_src[i];
        end
    end

    assign w_sh     = w_bus[4:0];
    assign w_sh_inv = 6'd32 - {1'b0, w_sh};
    assign w_sra    = $signed(r_y) >>> w_sh;
    assign w_prod   = {{32{r_y[31]}}, r_y} * {{32{w_bus[31]}}, w_bus};

    // Signed divide done on magnitudes so the most-negative dividend never overflows.
    assign w_div_a = r_y[31]   ? -r_y   : r_y;
    assign w_div_b = w_bus[31] ? -w_bus : w_bus;
    assign w_quo_m = w_div_a / w_div_b;
    assign w_rem_m = w_div_a % w_div_b;
    assign w_quo   = (r_y[31] ^ w_bus[31]) ? -w_quo_m : w_quo_m;
    assign w_rem   = r_y[31] ? -w_rem_m : w_rem_m;

    always_comb begin
        w_alu = '0;
        case (ALUControl)
            16'd0:  w_alu = {32'h0, w_bus + 32'd1};
            16'd1:  w_alu = {32'h0, r_y + w_bus};
            16'd2:  w_alu = {32'h0, r_y & w_bus};
            16'd3:  w_alu = {32'h0, r_y | w_bus};
            16'd4:  w_alu = {32'h0, r_y >> w_sh};
            16'd5:  w_alu = {32'h0, w_sra};
            16'd6:  w_alu = {32'h0, r_y << w_sh};
            16'd7:  w_alu = {32'h0, (r_y >> w_sh) | (r_y << w_sh_inv)};
            16'd8:  w_alu = {32'h0, (r_y << w_sh) | (r_y >> w_sh_inv)};
            16'd9:  w_alu = w_prod;
            16'd10: w_alu = (w_bus == 32'h0) ? {r_y, 32'hFFFF_FFFF} : {w_rem, w_quo};
            16'd11: w_alu = {32'h0, -w_bus};
            16'd12: w_alu = {32'h0, ~w_bus};
            16'd13: w_alu = {32'h0, r_y - w_bus};
            16'd14: w_alu = {32'h0, w_bus};
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_zhi <= '0;
            r_zlo <= '0;
            r_pc  <= '0;
            r_mdr <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_y   <= '0;
            r_rb  <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (Rin[i]) r_gpr[i] <= w_bus;
            end
            if (Rin[16]) r_hi <= w_bus;
            if (Rin[17]) r_lo <= w_bus;
            if (Rin[19]) begin
                r_zhi <= w_alu[63:32];
                r_zlo <= w_alu[31:0];
            end
            if (Rin[20] || PCjump) r_pc <= w_bus;
            if (Rin[21]) r_mdr <= MDRread ? Mdatain : w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (MARin) r_mar <= w_bus;
            if (RYin)  r_y   <= w_bus;
            if (RBin)  r_rb  <= w_bus;
        end
    end

    assign BusMuxOut = w_bus;
    assign IR        = r_ir;
    assign MAR       = r_mar;

endmodule

// File: tb/tb_data_path.sv
// Directed and randomized checks of data_path against a scoreboard of register
// contents and an arithmetic ALU reference.
module tb_data_path;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic [15:0] ALUControl;
    logic [31:0] Rin, Rout;
    logic        IRin, MARin, RZout, RYin, RBin, PCjump, MDRread;
    logic [31:0] BusMuxOut, IR, MAR;

    data_path dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .ALUControl(ALUControl),
        .Rin(Rin), .Rout(Rout), .IRin(IRin), .MARin(MARin), .RZout(RZout),
        .RYin(RYin), .RBin(RBin), .PCjump(PCjump), .MDRread(MDRread),
        .BusMuxOut(BusMuxOut), .IR(IR), .MAR(MAR)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo, m_zh, m_zl, m_pc, m_mdr, m_rb, m_ir, m_mar, m_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_hi = '0; m_lo = '0; m_zh = '0; m_zl = '0; m_pc = '0;
        m_mdr = '0; m_rb = '0; m_ir = '0; m_mar = '0; m_y = '0;
    endtask

    function automatic logic [31:0] c_const(input logic [31:0] ir);
        logic signed [18:0] imm;
        int v;
        imm = ir[18:0];
        v = int'(imm);
        return v;
    endfunction

    function automatic logic [31:0] src_val(input int i, input logic rz);
        if (i < 16) return (i == 0 && rz) ? 32'h0 : m_r[i];
        case (i)
            16: return m_hi;
            17: return m_lo;
            18: return m_zh;
            19: return m_zl;
            20: return m_pc;
            21: return m_mdr;
            22: return m_rb;
            23: return c_const(m_ir);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_bus(input logic [31:0] rout, input logic rz);
        for (int i = 0; i < 32; i++) begin
            if (rout[i]) return src_val(i, rz);
        end
        return 32'h0;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [15:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int     s;
        longint sa, sb, q, r;
        logic [31:0] w;
        s  = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        w  = a;
        case (op)
            16'd0:  return {32'h0, b + 32'd1};
            16'd1:  return {32'h0, a + b};
            16'd2:  return {32'h0, a & b};
            16'd3:  return {32'h0, a | b};
            16'd4:  return {32'h0, a >> s};
            16'd5:  return {32'h0, 32'(sa >>> s)};
            16'd6:  return {32'h0, a << s};
            16'd7: begin
                repeat (s) w = {w[0], w[31:1]};
                return {32'h0, w};
            end
            16'd8: begin
                repeat (s) w = {w[30:0], w[31]};
                return {32'h0, w};
            end
            16'd9:  return 64'(sa * sb);
            16'd10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            16'd11: return {32'h0, 32'(-sb)};
            16'd12: return {32'h0, ~b};
            16'd13: return {32'h0, 32'(sa - sb)};
            16'd14: return {32'h0, b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic idle();
        Mdatain = '0; ALUControl = '0; Rin = '0; Rout = '0;
        IRin = 0; MARin = 0; RZout = 0; RYin = 0; RBin = 0; PCjump = 0; MDRread = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_src(input string tag, input int src, input logic [31:0] exp);
        Rout = 32'h1 << src;
        RZout = 0;
        #1;
        chk(tag, BusMuxOut, exp);
        Rout = '0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle();
        Mdatain = v; MDRread = 1; Rin[21] = 1;
        tick();
        idle();
        m_mdr = v;
    endtask

    task automatic set_reg(input int idx, input logic [31:0] v);
        load_mdr(v);
        Rout[21] = 1; Rin[idx] = 1;
        tick();
        idle();
        if (idx < 16) m_r[idx] = v;
        else if (idx == 16) m_hi = v;
        else if (idx == 17) m_lo = v;
        else if (idx == 20) m_pc = v;
    endtask

    task automatic set_y(input logic [31:0] v);
        load_mdr(v);
        Rout[21] = 1; RYin = 1;
        tick();
        idle();
        m_y = v;
    endtask

    task automatic alu(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b);
        set_y(a);
        load_mdr(b);
        Rout[21] = 1; ALUControl = op; Rin[19] = 1;
        tick();
        idle();
        {m_zh, m_zl} = ref_alu(op, a, b);
    endtask

    logic [31:0] a, b, v, mask;
    logic [15:0] op;
    logic        rz;
    int          idx;

    initial begin
        idle();
        model_reset();

        // Reset with every enable asserted
        clear = 0;
        Rin = '1; Rout = '1; IRin = 1; MARin = 1; RYin = 1; RBin = 1; PCjump = 1;
        MDRread = 1; Mdatain = 32'hDEAD_BEEF; ALUControl = 16'd0;
        tick();
        tick();
        chk("rst_ir", IR, 32'h0);
        chk("rst_mar", MAR, 32'h0);
        chk("rst_bus", BusMuxOut, 32'h0);
        idle();
        clear = 1;
        tick();
        for (int i = 0; i < 24; i++) check_src($sformatf("rst_src%0d", i), i, 32'h0);
        chk("rst_ir_rel", IR, 32'h0);
        chk("rst_mar_rel", MAR, 32'h0);

        // Register preload
        load_mdr(32'h34);
        check_src("mdr_34", 21, 32'h34);
        set_reg(5, 32'h34);
        check_src("r5", 5, 32'h34);
        set_reg(6, 32'h45);
        check_src("r6", 6, 32'h45);
        set_reg(2, 32'h67);
        check_src("r2", 2, 32'h67);

        // Fetch
        Rout[20] = 1; MARin = 1; Rin[19] = 1; ALUControl = 16'd0;
        tick();
        idle();
        m_mar = m_pc;
        {m_zh, m_zl} = ref_alu(16'd0, m_y, m_pc);
        chk("fetch_mar", MAR, 32'h0);
        check_src("fetch_zlo", 19, 32'h1);
        check_src("fetch_zhi", 18, 32'h0);
        Rout[19] = 1; Rin[20] = 1;
        tick();
        idle();
        m_pc = m_zl;
        check_src("fetch_pc", 20, 32'h1);
        load_mdr(32'h112B_0000);
        Rout[21] = 1; IRin = 1;
        tick();
        idle();
        m_ir = m_mdr;
        chk("fetch_ir", IR, 32'h112B_0000);

        // SUB R5 - R6
        Rout[5] = 1; RYin = 1;
        tick();
        idle();
        m_y = m_r[5];
        Rout[6] = 1; ALUControl = 16'd13; Rin[19] = 1;
        tick();
        idle();
        {m_zh, m_zl} = ref_alu(16'd13, m_y, m_r[6]);
        check_src("sub_zlo", 19, 32'hFFFF_FFEF);
        Rout[19] = 1; Rin[2] = 1;
        tick();
        idle();
        m_r[2] = m_zl;
        check_src("sub_r2", 2, 32'hFFFF_FFEF);

        // MUL / DIV
        alu(16'd9, 32'hFFFF_FFFD, 32'd7);
        check_src("mul_hi", 18, 32'hFFFF_FFFF);
        check_src("mul_lo", 19, 32'hFFFF_FFEB);
        alu(16'd10, 32'd17, 32'd5);
        check_src("div_lo", 19, 32'd3);
        check_src("div_hi", 18, 32'd2);
        alu(16'd10, 32'd17, 32'd0);
        check_src("div0_lo", 19, 32'hFFFF_FFFF);
        check_src("div0_hi", 18, 32'd17);
        alu(16'd7, 32'h1234_5678, 32'd0);
        check_src("ror0", 19, 32'h1234_5678);
        alu(16'd8, 32'h8000_0001, 32'd4);
        check_src("rol4", 19, 32'h0000_0018);

        // Bus priority and base-zero
        set_reg(0, 32'd9);
        Rout = 32'h0000_0021;
        #1;
        chk("prio_r0", BusMuxOut, 32'd9);
        Rout = 32'h1; RZout = 1;
        #1;
        chk("basezero", BusMuxOut, 32'h0);
        Rout = 32'h0000_0020;
        #1;
        chk("rz_r5", BusMuxOut, 32'h34);
        Rout = '0; RZout = 0;
        #1;
        chk("bus_none", BusMuxOut, 32'h0);
        Rout = 32'hFF00_0000;
        #1;
        chk("bus_ignored", BusMuxOut, 32'h0);
        idle();

        // C sign extension, PCjump, RB, HI, LO
        load_mdr(32'h112C_0005);
        Rout[21] = 1; IRin = 1;
        tick();
        idle();
        m_ir = m_mdr;
        check_src("c_neg", 23, 32'hFFFC_0005);
        load_mdr(32'hCAFE_0010);
        Rout[21] = 1; PCjump = 1; RBin = 1;
        tick();
        idle();
        m_pc = m_mdr; m_rb = m_mdr;
        check_src("pcjump", 20, 32'hCAFE_0010);
        check_src("rb", 22, 32'hCAFE_0010);
        set_reg(16, 32'hAAAA_0001);
        set_reg(17, 32'h5555_0002);
        check_src("hi", 16, 32'hAAAA_0001);
        check_src("lo", 17, 32'h5555_0002);

        // Z as both source and destination loads the pre-edge value
        set_y(32'd5);
        Rout[19] = 1; ALUControl = 16'd1; Rin[19] = 1;
        tick();
        idle();
        v = m_zl + 32'd5;
        {m_zh, m_zl} = ref_alu(16'd1, m_y, m_zl);
        check_src("z_self", 19, v);

        // Reset asserted mid-transfer
        set_reg(7, 32'h55);
        load_mdr(32'h77);
        Rout[21] = 1; Rin[7] = 1;
        #2;
        clear = 0;
        @(posedge clock);
        #1;
        idle();
        clear = 1;
        model_reset();
        tick();
        check_src("midrst_r7", 7, 32'h0);
        check_src("midrst_mdr", 21, 32'h0);

        // Randomized ALU operations
        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, 19);
            op = (idx < 16) ? 16'(idx) : 16'($urandom);
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(0, 40);
                1: b = 32'h0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            alu(op, a, b);
            check_src($sformatf("rnd_lo_op%0d", op), 19, m_zl);
            check_src($sformatf("rnd_hi_op%0d", op), 18, m_zh);
        end

        // Randomized register writes and multi-select bus reads
        for (int n = 0; n < 100; n++) begin
            idx = $urandom_range(0, 17);
            set_reg(idx, $urandom);
            mask = $urandom & $urandom & $urandom;
            rz = 1'($urandom_range(0, 1));
            Rout = mask; RZout = rz;
            #1;
            chk($sformatf("rnd_bus_%h", mask), BusMuxOut, exp_bus(mask, rz));
            idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
